// File: rtl/frac_pkg.sv
// Shared types and constants for the fraction reducer: FSM state encoding and
// the default operand width.
package frac_pkg;

  localparam int FRAC_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_GCD = 3'd1,
    DIV_NUM  = 3'd2,
    DIV_DEN  = 3'd3,
    OUT      = 3'd4
  } frac_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per cycle, MSB first,
// WIDTH cycles per division. The remainder is discarded.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   rem_shift;
  logic             fits;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // quo_q starts as the dividend; its MSB feeds the remainder while the new
  // quotient bit shifts in at the bottom.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    fits      = rem_q[WIDTH] | (rem_shift >= {1'b0, dsr_q});
    rem_step  = fits ? (rem_shift - {1'b0, dsr_q}) : rem_shift;
    quo_step  = {quo_q[WIDTH-2:0], fits};
    last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = '0;
      quo_d  = dividend;
      dsr_d  = divisor;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        busy_d = 1'b0;
      end
    end
  end

  // The quotient is presented combinationally during the final iteration so
  // the caller can capture it and restart on the same edge.
  assign busy     = busy_q;
  assign done     = last;
  assign quotient = quo_step;

endmodule

// File: rtl/frac_reducer.sv
// Reduces num/den by a GCD supplied by an external stage, dividing both
// terms with one shared sequential divider.
module frac_reducer
  import frac_pkg::*;
#(
  parameter int WIDTH = FRAC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] num_in,
  input  logic [WIDTH-1:0] den_in,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] num_out,
  output logic [WIDTH-1:0] den_out,
  output logic             err,
  output logic             busy,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and data is held while valid is
  // high and ready is low.

  frac_state_e      state_q, state_d;
  logic             ready_en_q;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [WIDTH-1:0] num_quo_q, num_quo_d;
  logic [WIDTH-1:0] num_out_q, num_out_d;
  logic [WIDTH-1:0] den_out_q, den_out_d;
  logic             err_q, err_d;

  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic             div_finish;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quotient)
  );

  // A divider that is idle while a division state is active cannot occur in
  // normal operation; treating it as finished keeps the FSM from wedging.
  assign div_finish = div_done || !div_busy;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (op_valid && op_ready) state_d = WAIT_GCD;
      end
      WAIT_GCD: begin
        if (gcd_done) state_d = (gcd_in != '0) ? DIV_NUM : OUT;
      end
      DIV_NUM: begin
        if (div_finish) state_d = DIV_DEN;
      end
      DIV_DEN: begin
        if (div_finish) state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_ready  = (state_q == IDLE) && ready_en_q;
    out_valid = (state_q == OUT);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  // ready_en_q keeps op_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      ready_en_q <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
      gcd_q      <= '0;
      num_quo_q  <= '0;
      num_out_q  <= '0;
      den_out_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      num_q      <= num_d;
      den_q      <= den_d;
      gcd_q      <= gcd_d;
      num_quo_q  <= num_quo_d;
      num_out_q  <= num_out_d;
      den_out_q  <= den_out_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    num_d     = num_q;
    den_d     = den_q;
    gcd_d     = gcd_q;
    num_quo_d = num_quo_q;
    num_out_d = num_out_q;
    den_out_d = den_out_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (op_valid && op_ready) begin
          num_d = num_in;
          den_d = den_in;
          err_d = 1'b0;
        end
      end
      WAIT_GCD: begin
        if (gcd_done) begin
          gcd_d = gcd_in;
          if (gcd_in == '0) begin
            num_out_d = '0;
            den_out_d = '0;
            err_d     = 1'b1;
          end
        end
      end
      DIV_NUM: begin
        if (div_finish) num_quo_d = div_quotient;
      end
      DIV_DEN: begin
        // Both outputs update together on entry to OUT so they hold their
        // previous values for the whole division.
        if (div_finish) begin
          num_out_d = num_quo_q;
          den_out_d = div_quotient;
        end
      end
      default: ;
    endcase
  end

  // The numerator division starts on the edge that samples gcd_done, and the
  // denominator division starts on the edge that finishes the numerator.
  always_comb begin
    div_start    = ((state_q == WAIT_GCD) && gcd_done && (gcd_in != '0)) ||
                   ((state_q == DIV_NUM) && div_finish);
    div_dividend = (state_q == DIV_NUM) ? den_q : num_q;
    div_divisor  = (state_q == WAIT_GCD) ? gcd_in : gcd_q;
  end

  assign num_out = num_out_q;
  assign den_out = den_out_q;
  assign err     = err_q;

endmodule

// File: tb/tb_frac_reducer.sv
// Self-checking bench for frac_reducer: drives fractions and GCD strobes,
// predicts {err, num_out, den_out} into a queue and checks latency and holds.
module tb_frac_reducer;
  import frac_pkg::*;

  localparam int W = FRAC_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] num_in = '0;
  logic [W-1:0] den_in = '0;
  logic         gcd_done = 1'b0;
  logic [W-1:0] gcd_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] num_out;
  logic [W-1:0] den_out;
  logic         err;
  logic         busy;
  logic [2:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] exp_q[$];
  logic [2*W:0] last_res = '0;

  frac_reducer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .num_in    (num_in),
    .den_in    (den_in),
    .gcd_done  (gcd_done),
    .gcd_in    (gcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_out   (num_out),
    .den_out   (den_out),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp_v, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic run_frac(input logic [W-1:0] n, input logic [W-1:0] d, input logic [W-1:0] g,
                          input int gcd_delay, input int hold, input bit noise);
    logic [2*W:0] exp_res;
    int guard;
    int lat;
    int exp_lat;
    guard = 0;
    while (!op_ready && guard < 50) begin
      step();
      guard++;
    end
    check("op_ready_wait", op_ready, 1);
    num_in   = n;
    den_in   = d;
    op_valid = 1'b1;
    if (g == '0) exp_res = {1'b1, {(2*W){1'b0}}};
    else         exp_res = {1'b0, n / g, d / g};
    exp_q.push_back(exp_res);
    step();
    op_valid = 1'b0;
    num_in   = W'($urandom);
    den_in   = W'($urandom);
    check("wait_busy", busy, 1);
    for (int k = 0; k < gcd_delay; k++) step();
    gcd_in   = g;
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    gcd_in   = W'($urandom);
    exp_lat  = (g == '0) ? 1 : 2 * W + 1;
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (noise && lat == 3) begin
        check("noise_state", dbg_state, DIV_NUM);
        gcd_done = 1'b1;
      end
      step();
      gcd_done = 1'b0;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (exp_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      exp_res  = exp_q.pop_front();
      last_res = exp_res;
      check("result", {err, num_out, den_out}, exp_res);
    end
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      op_valid  = 1'b1;
      num_in    = W'($urandom);
      step();
      check("hold_result", {err, num_out, den_out}, exp_res);
      check("hold_valid", out_valid, 1);
      check("hold_op_ready", op_ready, 0);
    end
    op_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_op_ready", op_ready, 1);
    check("post_hold", {err, num_out, den_out}, exp_res);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    int a;
    int b;
    int g;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {err, num_out, den_out}, 0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b0;
    check("rel_op_ready_low", op_ready, 0);
    step();
    check("rel_op_ready_high", op_ready, 1);

    run_frac(8'd12, 8'd18, 8'd6, 2, 0, 1'b0);
    run_frac(8'd0, 8'd0, 8'd0, 0, 0, 1'b0);
    run_frac(8'd255, 8'd1, 8'd1, 0, 0, 1'b0);
    run_frac(8'd0, 8'd200, 8'd200, 1, 0, 1'b0);
    run_frac(8'd35, 8'd49, 8'd7, 0, 5, 1'b0);

    // gcd_done while idle must be ignored
    gcd_in   = 8'd5;
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    step();
    check("idle_gcd_state", dbg_state, IDLE);
    check("idle_gcd_valid", out_valid, 0);
    check("idle_gcd_busy", busy, 0);
    check("idle_gcd_outputs", {err, num_out, den_out}, last_res);

    run_frac(8'd100, 8'd60, 8'd20, 3, 0, 1'b1);

    // reset in the third cycle of DIV_NUM
    num_in   = 8'd12;
    den_in   = 8'd18;
    op_valid = 1'b1;
    step();
    op_valid = 1'b0;
    gcd_in   = 8'd6;
    gcd_done = 1'b1;
    step();
    gcd_done = 1'b0;
    step();
    step();
    check("mid_state", dbg_state, DIV_NUM);
    #1 rst_n = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_flags", {out_valid, busy, op_ready}, 0);
    check("mid_rst_outputs", {err, num_out, den_out}, 0);
    step();
    step();
    rst_n = 1'b0;
    check("mid_rel_op_ready_low", op_ready, 0);
    seen = 0;
    step();
    check("mid_rel_op_ready_high", op_ready, 1);
    for (int k = 0; k < 24; k++) begin
      if (out_valid) seen = 1;
      step();
    end
    check("no_valid_after_reset", seen, 0);

    run_frac(8'd8, 8'd4, 8'd4, 0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      g = $urandom_range(1, 12);
      a = $urandom_range(0, 255 / g);
      b = $urandom_range(1, 255 / g);
      run_frac(W'(a * g), W'(b * g), W'(g), $urandom_range(0, 3), $urandom_range(0, 2), i[0]);
    end

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frac_reducer.md
FRAC_REDUCER -- requirements
Module: frac_reducer

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, as the operand, GCD and quotient bit width.
REQ-002 The block SHALL provide the following ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-high.
- op_valid  in  1  fraction offered; the same cycle pulses start to the GCD stage.
- op_ready  out  1  block can accept a fraction; high only in IDLE.
- num_in  in  WIDTH  numerator, sampled on the op_valid && op_ready edge.
- den_in  in  WIDTH  denominator, sampled on the same edge.
- gcd_done  in  1  one-cycle result strobe from the GCD stage.
- gcd_in  in  WIDTH  GCD result, sampled when gcd_done is high.
- out_valid  out  1  reduced fraction available.
- out_ready  in  1  consumer accepts the result.
- num_out  out  WIDTH  reduced numerator.
- den_out  out  WIDTH  reduced denominator.
- err  out  1  GCD was zero (0/0 input); qualified by out_valid.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, WAIT_GCD, DIV_NUM, DIV_DEN, OUT.
REQ-004 IDLE: on op_valid high, the block SHALL capture num_in and den_in and move to WAIT_GCD; otherwise it stays in IDLE.
REQ-005 WAIT_GCD: on gcd_done high, the block SHALL capture gcd_in as divisor.
- gcd_in nonzero: move to DIV_NUM.
- gcd_in zero: move directly to OUT with num_out=0, den_out=0, err=1.
- Otherwise: stay in WAIT_GCD indefinitely; there is no timeout.
REQ-006 gcd_done SHALL be ignored in every state other than WAIT_GCD.
REQ-007 DIV_NUM SHALL compute captured_num / divisor by restoring shift-subtract division, one quotient bit per cycle, MSB first, lasting exactly WIDTH cycles, then move to DIV_DEN.
REQ-008 DIV_DEN SHALL compute captured_den / divisor the same way in exactly WIDTH cycles, then move to OUT.
REQ-009 Remainders SHALL be discarded; the partial remainder register SHALL be WIDTH+1 bits so no subtraction overflows.
REQ-010 out_valid SHALL be high exactly while in OUT.
REQ-011 num_out, den_out and err SHALL be stable throughout OUT.
REQ-012 Latency SHALL be exactly 2*WIDTH+1 clock edges from the edge sampling gcd_done (nonzero GCD) to the first cycle of out_valid high; 17 for WIDTH=8.
REQ-013 In OUT, out_ready high SHALL complete the transfer and return the FSM to IDLE on that edge; out_ready low SHALL hold OUT and all outputs unchanged.
REQ-014 op_valid SHALL be ignored outside IDLE; a new fraction is accepted no earlier than the cycle after the OUT handshake.
REQ-015 num_out and den_out SHALL hold their last values outside OUT.
REQ-016 err SHALL be cleared on every new capture in IDLE.
REQ-017 A numerator of zero with a nonzero denominator SHALL produce num_out=0, den_out=1 through the normal division path.

Reset
REQ-018 While rst_n is high, the block SHALL force, asynchronously:
- state=IDLE, out_valid=0, err=0, busy=0, op_ready=0
- num_out=0, den_out=0, all internal registers 0.
REQ-019 op_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-020 Reset asserted mid-operation (any state) SHALL abort the operation, and no out_valid pulse SHALL follow it.

Structure
REQ-021 Package frac_pkg SHALL hold the FSM state enumeration and the WIDTH default constant.
REQ-022 Division SHALL be implemented in one sub-module, seq_divider, with ports start, dividend, divisor, busy, done, quotient.
REQ-023 seq_divider SHALL be instantiated once and reused for DIV_NUM then DIV_DEN.

Verification
REQ-024 num=12, den=18, gcd_in=6 -> num_out=2, den_out=3, err=0, out_valid 17 cycles after gcd_done.
REQ-025 num=0, den=0, gcd_in=0 -> next cycle OUT, num_out=0, den_out=0, err=1.
REQ-026 num=255, den=1, gcd_in=1 -> 255/1; then num=0, den=200, gcd_in=200 -> 0/1.
REQ-027 out_ready held low 5 cycles in OUT -> outputs stable, op_ready low, op_valid pulses ignored; release -> IDLE next edge.
REQ-028 gcd_done pulsed while in IDLE and during DIV_NUM -> no state or output change.
REQ-029 rst_n asserted during cycle 3 of DIV_NUM -> immediate IDLE, all outputs zero, no out_valid; next 8/4, gcd 4 -> 2/1.
